instr_fetch: RTL and testbench

Instruction fetch unit for the 8-bit CPU. It generates program addresses, reads instruction bytes from instruction memory through a request/response handshake, and buffers them in a small prefetch queue. It presents them in order to the control FSM over a valid/ready interface. It is the producer of the `instr` byte that the control FSM decodes into register addresses and the operation.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/fetch_fifo.sv | 58 +++++
 rtl/instr_fetch.sv | 122 ++++++++++++
 tb/tb_instr_fetch.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: opcode encodings, instruction field
// positions and the fetch FSM state type.
package cpu_pkg;

    localparam logic [1:0] ONE  = 2'b00;
    localparam logic [1:0] ADD  = 2'b01;
    localparam logic [1:0] SUB  = 2'b10;
    localparam logic [1:0] SWAP = 2'b11;

    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 6;
    localparam int RA_MSB  = 5;
    localparam int RA_LSB  = 3;
    localparam int RB_MSB  = 2;
    localparam int RB_LSB  = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DROP = 2'd3
    } fetch_state_t;

    function automatic logic [1:0] instr_opcode(input logic [7:0] i_instr);
        return i_instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead prefetch queue. Clear has priority over push/pop; push and pop
// together on a full queue keep the count unchanged.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_head,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != FULL_CNT) || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
            else if (w_do_pop && !w_do_push) r_count <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_clear) r_mem[r_wr_ptr] <= i_wdata;
    end

    // Empty queue presents zeros so the head reads 0 out of reset.
    assign o_head  = (r_count == '0) ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding memory read at a time, results
// buffered in a prefetch queue and handed to the controller via valid/ready.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int                 ADDR_W   = 8,
    parameter int                 DATA_W   = 8,
    parameter int                 DEPTH    = 2,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
)(
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic              halt,
    output logic              busy
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_M1 = CNT_W'(DEPTH - 1);

    fetch_state_t        r_state;
    fetch_state_t        w_next_state;
    logic [ADDR_W-1:0]   r_fetch_pc;
    logic [ADDR_W-1:0]   w_fetch_pc_next;
    logic [ADDR_W-1:0]   r_req_pc;
    logic                r_mem_req;
    logic                w_push;
    logic                w_pop;
    logic                w_room_idle;
    logic                w_room_after_push;
    logic [CNT_W-1:0]    w_count;
    logic [DATA_W+ADDR_W-1:0] w_head;

    assign instr_valid = (w_count != '0);
    assign w_pop       = instr_valid && instr_ready && !flush;

    assign w_room_idle       = (w_count < DEPTH_C) && !halt;
    assign w_room_after_push = (w_pop ? (w_count < DEPTH_C) : (w_count < DEPTH_M1)) && !halt;

    always_comb begin
        w_next_state    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        w_push          = 1'b0;
        case (r_state)
            S_IDLE: if (w_room_idle) w_next_state = S_REQ;
            S_REQ: begin
                if (mem_ack) begin
                    w_next_state    = S_WAIT;
                    w_fetch_pc_next = r_fetch_pc + ADDR_W'(1);
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    w_push       = 1'b1;
                    w_next_state = w_room_after_push ? S_REQ : S_IDLE;
                end
            end
            S_DROP: if (mem_rvalid) w_next_state = halt ? S_IDLE : S_REQ;
            default: w_next_state = S_IDLE;
        endcase

        // A flush may withdraw an unacked request but must still absorb any
        // response already owed by memory, hence S_DROP.
        if (flush) begin
            w_fetch_pc_next = flush_pc;
            w_push          = 1'b0;
            case (r_state)
                S_IDLE:  w_next_state = halt ? S_IDLE : S_REQ;
                S_REQ:   w_next_state = mem_ack ? S_DROP : S_REQ;
                S_WAIT:  w_next_state = mem_rvalid ? (halt ? S_IDLE : S_REQ) : S_DROP;
                S_DROP:  w_next_state = mem_rvalid ? (halt ? S_IDLE : S_REQ) : S_DROP;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= '0;
            r_mem_req  <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_fetch_pc <= w_fetch_pc_next;
            r_mem_req  <= (w_next_state == S_REQ);
            if (r_state == S_REQ && mem_ack) r_req_pc <= r_fetch_pc;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W + ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (flush),
        .i_wdata ({mem_rdata, r_req_pc}),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign mem_req  = r_mem_req;
    assign mem_addr = r_fetch_pc;
    assign instr    = w_head[DATA_W+ADDR_W-1:ADDR_W];
    assign instr_pc = w_head[ADDR_W-1:0];
    assign busy     = (r_state == S_REQ) || (r_state == S_WAIT) || (r_state == S_DROP);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch; memory returns (addr ^ 8'h5A) for each read.
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack = 1'b1;
    logic       mem_rvalid = 1'b0;
    logic [7:0] mem_rdata = 8'h00;
    logic [7:0] instr;
    logic [7:0] instr_pc;
    logic       instr_valid;
    logic       instr_ready = 1'b1;
    logic       flush = 1'b0;
    logic [7:0] flush_pc = 8'h00;
    logic       halt = 1'b0;
    logic       busy;

    int checks = 0;
    int failures = 0;

    int         rsp_extra = 0;
    logic       pend = 1'b0;
    logic [7:0] pa = 8'h00;
    int         cnt = 0;
    logic       saw;

    always #5 clk = ~clk;

    instr_fetch #(
        .ADDR_W   (8),
        .DATA_W   (8),
        .DEPTH    (2),
        .RESET_PC (8'h00)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .halt        (halt),
        .busy        (busy)
    );

    // Memory model: response rsp_extra cycles after the cycle following ack.
    always @(posedge clk) begin
        if (!rst_n)               pend = 1'b0;
        else if (mem_rvalid)      pend = 1'b0;
        else if (pend && cnt > 0) cnt--;
        if (rst_n && mem_req && mem_ack) begin
            pend = 1'b1;
            pa   = mem_addr;
            cnt  = rsp_extra;
        end
        #1;
        mem_rvalid = pend && (cnt == 0);
        mem_rdata  = mem_rvalid ? (pa ^ 8'h5A) : 8'h00;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_instr(input string tag, input logic [7:0] pc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!instr_valid && n < 40);
        chk({tag, " valid"}, 32'(instr_valid), 32'd1);
        chk({tag, " pc"},    32'(instr_pc),    32'(pc));
        chk({tag, " data"},  32'(instr),       32'(pc ^ 8'h5A));
    endtask

    initial begin
        #2;
        chk("rst mem_req",  32'(mem_req),     32'd0);
        chk("rst mem_addr", 32'(mem_addr),    32'h00);
        chk("rst instr",    32'(instr),       32'h00);
        chk("rst instr_pc", 32'(instr_pc),    32'h00);
        chk("rst valid",    32'(instr_valid), 32'd0);
        chk("rst busy",     32'(busy),        32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Sequential stream from address 0
        wait_instr("seq0", 8'h00);
        wait_instr("seq1", 8'h01);
        wait_instr("seq2", 8'h02);
        wait_instr("seq3", 8'h03);

        // Asynchronous reset mid-stream
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst mem_req",  32'(mem_req),     32'd0);
        chk("arst valid",    32'(instr_valid), 32'd0);
        chk("arst busy",     32'(busy),        32'd0);
        chk("arst mem_addr", 32'(mem_addr),    32'h00);
        instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Queue fills to depth with ready low, then fetching stops
        repeat (12) @(negedge clk);
        chk("fill valid",    32'(instr_valid), 32'd1);
        chk("fill pc",       32'(instr_pc),    32'h00);
        chk("fill data",     32'(instr),       32'h5A);
        chk("fill mem_req",  32'(mem_req),     32'd0);
        chk("fill busy",     32'(busy),        32'd0);
        chk("fill mem_addr", 32'(mem_addr),    32'h02);
        saw = 1'b0;
        repeat (4) begin
            @(negedge clk);
            saw = saw | mem_req;
        end
        chk("fill no req", 32'(saw), 32'd0);
        instr_ready = 1'b1;
        wait_instr("drain1", 8'h01);
        wait_instr("drain2", 8'h02);

        // Address wrap from FF to 00
        flush_pc = 8'hFE;
        flush    = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("wrapflush valid", 32'(instr_valid), 32'd0);
        wait_instr("wrapFE", 8'hFE);
        wait_instr("wrapFF", 8'hFF);
        wait_instr("wrap00", 8'h00);
        wait_instr("wrap01", 8'h01);

        // Flush while waiting for read data (response delayed)
        chk("f40 pre req",  32'(mem_req),  32'd1);
        chk("f40 pre addr", 32'(mem_addr), 32'h02);
        rsp_extra = 1;
        @(posedge clk);
        #1;
        chk("f40 wait busy", 32'(busy), 32'd1);
        flush_pc = 8'h40;
        flush    = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("f40 valid",   32'(instr_valid), 32'd0);
        chk("f40 busy",    32'(busy),        32'd1);
        chk("f40 mem_req", 32'(mem_req),     32'd0);
        wait_instr("f40", 8'h40);
        wait_instr("f41", 8'h41);

        // Flush coinciding with rvalid and a pop
        rsp_extra   = 0;
        instr_ready = 1'b0;
        flush_pc    = 8'h80;
        flush       = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        wait_instr("f80", 8'h80);
        chk("f80 req81", 32'(mem_req), 32'd1);
        @(posedge clk);
        #1;
        instr_ready = 1'b1;
        flush_pc    = 8'hC0;
        flush       = 1'b1;
        chk("fC0 pre valid", 32'(instr_valid), 32'd1);
        @(posedge clk);
        #1 flush = 1'b0;
        chk("fC0 valid",    32'(instr_valid), 32'd0);
        chk("fC0 mem_req",  32'(mem_req),     32'd1);
        chk("fC0 mem_addr", 32'(mem_addr),    32'hC0);
        wait_instr("fC0", 8'hC0);
        wait_instr("fC1", 8'hC1);

        // Halt while a read is outstanding
        chk("halt pre addr", 32'(mem_addr), 32'hC2);
        @(posedge clk);
        #1 halt = 1'b1;
        wait_instr("haltC2", 8'hC2);
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            saw = saw | mem_req;
        end
        chk("halt no req", 32'(saw),  32'd0);
        chk("halt busy",   32'(busy), 32'd0);
        halt = 1'b0;
        wait_instr("resumeC3", 8'hC3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
